// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing and 512x342 SE window, shared count type and
// sync polarity constants for the VGA timing generator.
package vga_timing_pkg;

  typedef logic [9:0] count_t;

  // Largest total that still fits count_t, and the span addressable by seX/seY.
  localparam int unsigned COUNT_SPAN   = 1024;
  localparam int unsigned SE_ADDR_SPAN = 512;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60 horizontal timing
  localparam int unsigned DEF_H_TOTAL      = 800;
  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_H_SYNC_START = 656;
  localparam int unsigned DEF_H_SYNC_END   = 752;

  // 640x480@60 vertical timing
  localparam int unsigned DEF_V_TOTAL      = 525;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_V_SYNC_START = 490;
  localparam int unsigned DEF_V_SYNC_END   = 492;

  // 512x342 SE window, centred in the active area
  localparam int unsigned DEF_SE_H_START  = 64;
  localparam int unsigned DEF_SE_H_WIDTH  = 512;
  localparam int unsigned DEF_SE_V_START  = 69;
  localparam int unsigned DEF_SE_V_HEIGHT = 342;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus registered active / SE / sync
// decodes of the next count, so every flag changes on the same edge as the
// count it describes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter int unsigned ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned SE_START   = DEF_SE_H_START,
  parameter int unsigned SE_SIZE    = DEF_SE_H_WIDTH,
  parameter bit          SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv_i,
  input  logic   qual_i,
  output count_t count_o,
  output count_t next_o,
  output logic   wrap_o,
  output logic   active_o,
  output logic   se_active_o,
  output logic   sync_o,
  output logic   start_o
);

  localparam bit BAD_PARAMS = (TOTAL > COUNT_SPAN) || (TOTAL == 0) ||
                              (ACTIVE > TOTAL) ||
                              (SYNC_END > TOTAL) || (SYNC_START >= SYNC_END) ||
                              (SE_START + SE_SIZE > ACTIVE);

  if (BAD_PARAMS) begin : g_bad_params
    $error("vga_axis_counter: illegal timing parameters");
  end

  localparam count_t C_LAST = count_t'(TOTAL - 1);

  count_t count_q, count_d;
  logic   active_q, active_d;
  logic   se_q, se_d;
  logic   sync_q, sync_d;

  // Next count and the decodes of that next value.
  always_comb begin
    count_d = count_q;
    if (!rst_n) begin
      count_d = '0;
    end else if (adv_i) begin
      count_d = (count_q == C_LAST) ? '0 : count_q + count_t'(1);
    end
    active_d = (32'(count_d) < ACTIVE);
    se_d     = (32'(count_d) >= SE_START) && (32'(count_d) < SE_START + SE_SIZE);
    sync_d   = ((32'(count_d) >= SYNC_START) && (32'(count_d) < SYNC_END)) ?
               SYNC_POL : ~SYNC_POL;
  end

  // Count and decode registers.
  always_ff @(posedge clk) begin
    count_q  <= count_d;
    active_q <= active_d;
    se_q     <= se_d;
    sync_q   <= sync_d;
  end

  assign count_o     = count_q;
  assign next_o      = count_d;
  assign wrap_o      = adv_i & (count_q == C_LAST);
  assign active_o    = active_q;
  assign se_active_o = se_q;
  assign sync_o      = sync_q;
  assign start_o     = qual_i & rst_n & (count_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters on one pixel
// clock, region flags, syncs, line/frame strobes and optional SE window
// addresses (enabled by macro VGA_SE_ADDR_EN; otherwise seX/seY are 0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END,
  parameter bit          H_SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter bit          V_SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int unsigned SE_H_START   = DEF_SE_H_START,
  parameter int unsigned SE_H_WIDTH   = DEF_SE_H_WIDTH,
  parameter int unsigned SE_V_START   = DEF_SE_V_START,
  parameter int unsigned SE_V_HEIGHT  = DEF_SE_V_HEIGHT
) (
  input  logic       pixClk,
  input  logic       nReset,
  input  logic       pixEn,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hActive,
  output logic       vActive,
  output logic       hSEActive,
  output logic       vSEActive,
  output logic       hSync,
  output logic       vSync,
  output logic       lineStart,
  output logic       frameStart,
  output logic [8:0] seX,
  output logic [8:0] seY
);

  if ((SE_H_WIDTH > SE_ADDR_SPAN) || (SE_V_HEIGHT > SE_ADDR_SPAN)) begin : g_bad_se
    $error("vga_timing_gen: SE window wider than the address range");
  end

  count_t h_next, v_next;
  logic   h_wrap;
  logic   v_wrap_unused;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .ACTIVE    (H_ACTIVE),
    .SYNC_START(H_SYNC_START),
    .SYNC_END  (H_SYNC_END),
    .SE_START  (SE_H_START),
    .SE_SIZE   (SE_H_WIDTH),
    .SYNC_POL  (H_SYNC_POL)
  ) u_h_axis (
    .clk        (pixClk),
    .rst_n      (nReset),
    .adv_i      (pixEn),
    .qual_i     (pixEn),
    .count_o    (hCount),
    .next_o     (h_next),
    .wrap_o     (h_wrap),
    .active_o   (hActive),
    .se_active_o(hSEActive),
    .sync_o     (hSync),
    .start_o    (lineStart)
  );

  // Vertical axis advances on the horizontal wrap; its start strobe is
  // qualified by lineStart so frameStart only fires on the first pixel.
  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .ACTIVE    (V_ACTIVE),
    .SYNC_START(V_SYNC_START),
    .SYNC_END  (V_SYNC_END),
    .SE_START  (SE_V_START),
    .SE_SIZE   (SE_V_HEIGHT),
    .SYNC_POL  (V_SYNC_POL)
  ) u_v_axis (
    .clk        (pixClk),
    .rst_n      (nReset),
    .adv_i      (h_wrap),
    .qual_i     (lineStart),
    .count_o    (vCount),
    .next_o     (v_next),
    .wrap_o     (v_wrap_unused),
    .active_o   (vActive),
    .se_active_o(vSEActive),
    .sync_o     (vSync),
    .start_o    (frameStart)
  );

`ifdef VGA_SE_ADDR_EN
  logic [8:0] se_x_q, se_x_d;
  logic [8:0] se_y_q, se_y_d;
  logic       h_se_next, v_se_next, se_line_done;

  // SE addresses derived from the next counts; seY steps once the last SE
  // pixel of an SE line has been shown.
  always_comb begin
    h_se_next    = (32'(h_next) >= SE_H_START) && (32'(h_next) < SE_H_START + SE_H_WIDTH);
    v_se_next    = (32'(v_next) >= SE_V_START) && (32'(v_next) < SE_V_START + SE_V_HEIGHT);
    se_line_done = pixEn && vSEActive && (32'(hCount) == SE_H_START + SE_H_WIDTH - 1);
    se_x_d       = h_se_next ? 9'(h_next - count_t'(SE_H_START)) : '0;
    se_y_d       = se_y_q;
    if (!v_se_next) begin
      se_y_d = '0;
    end else if (se_line_done) begin
      se_y_d = (32'(se_y_q) == SE_V_HEIGHT - 1) ? '0 : se_y_q + 9'd1;
    end
    if (!nReset) begin
      se_x_d = '0;
      se_y_d = '0;
    end
  end

  // SE address registers.
  always_ff @(posedge pixClk) begin
    se_x_q <= se_x_d;
    se_y_q <= se_y_d;
  end

  assign seX = se_x_q;
  assign seY = se_y_q;
`else
  logic next_unused;
  assign next_unused = ^{h_next, v_next};
  assign seX = '0;
  assign seY = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, high-true-sync and a small
// fast-frame configuration driven from shared inputs.
module tb_vga_timing_gen;

`ifdef VGA_SE_ADDR_EN
  localparam bit SE_EN = 1'b1;
`else
  localparam bit SE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic pix_en, n_reset;

  logic [9:0] d_h, d_v, p_h, p_v, s_h, s_v;
  logic       d_ha, d_va, d_hse, d_vse, d_hs, d_vs, d_ls, d_fs;
  logic       p_ha, p_va, p_hse, p_vse, p_hs, p_vs, p_ls, p_fs;
  logic       s_ha, s_va, s_hse, s_vse, s_hs, s_vs, s_ls, s_fs;
  logic [8:0] d_sx, d_sy, p_sx, p_sy, s_sx, s_sy;

  vga_timing_gen dut (
    .pixClk(clk), .nReset(n_reset), .pixEn(pix_en),
    .hCount(d_h), .vCount(d_v), .hActive(d_ha), .vActive(d_va),
    .hSEActive(d_hse), .vSEActive(d_vse), .hSync(d_hs), .vSync(d_vs),
    .lineStart(d_ls), .frameStart(d_fs), .seX(d_sx), .seY(d_sy)
  );

  vga_timing_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut_p (
    .pixClk(clk), .nReset(n_reset), .pixEn(pix_en),
    .hCount(p_h), .vCount(p_v), .hActive(p_ha), .vActive(p_va),
    .hSEActive(p_hse), .vSEActive(p_vse), .hSync(p_hs), .vSync(p_vs),
    .lineStart(p_ls), .frameStart(p_fs), .seX(p_sx), .seY(p_sy)
  );

  vga_timing_gen #(
    .H_TOTAL(20), .H_ACTIVE(16), .H_SYNC_START(17), .H_SYNC_END(19),
    .V_TOTAL(12), .V_ACTIVE(10), .V_SYNC_START(10), .V_SYNC_END(12),
    .SE_H_START(2), .SE_H_WIDTH(8), .SE_V_START(3), .SE_V_HEIGHT(5)
  ) dut_s (
    .pixClk(clk), .nReset(n_reset), .pixEn(pix_en),
    .hCount(s_h), .vCount(s_v), .hActive(s_ha), .vActive(s_va),
    .hSEActive(s_hse), .vSEActive(s_vse), .hSync(s_hs), .vSync(s_vs),
    .lineStart(s_ls), .frameStart(s_fs), .seX(s_sx), .seY(s_sy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, return at the falling edge
  // where outputs are sampled.
  task automatic step(input logic en, input logic rst);
    @(posedge clk);
    #1;
    pix_en  = en;
    n_reset = rst;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_hCount"}, int'(d_h), 0);
    chk({tag, "_vCount"}, int'(d_v), 0);
    chk({tag, "_hActive"}, int'(d_ha), 1);
    chk({tag, "_vActive"}, int'(d_va), 1);
    chk({tag, "_hSEActive"}, int'(d_hse), 0);
    chk({tag, "_vSEActive"}, int'(d_vse), 0);
    chk({tag, "_hSync"}, int'(d_hs), 1);
    chk({tag, "_vSync"}, int'(d_vs), 1);
    chk({tag, "_lineStart"}, int'(d_ls), 0);
    chk({tag, "_frameStart"}, int'(d_fs), 0);
    chk({tag, "_seX"}, int'(d_sx), 0);
    chk({tag, "_seY"}, int'(d_sy), 0);
    chk({tag, "_pol_hSync"}, int'(p_hs), 0);
    chk({tag, "_pol_vSync"}, int'(p_vs), 0);
  endtask

  typedef struct {
    int h;
    bit ha, hse, hs, ls, fs;
    int sx;
  } hvec_t;

  hvec_t tbl[12];

  initial begin
    int cur, hs_low, ha_high;
    int mh, mv, cnt_err, stb_err, dbl, ls_cnt;
    bit prev_ls, prev_fs, en;
    int f_err, a_err, fs_cnt, fs_at[3];

    pix_en  = 1'b0;
    n_reset = 1'b0;

    //             h    ha hse hs ls fs  sx
    tbl[0]  = '{   0, 1, 0, 1, 1, 1,   0};
    tbl[1]  = '{  63, 1, 0, 1, 0, 0,   0};
    tbl[2]  = '{  64, 1, 1, 1, 0, 0,   0};
    tbl[3]  = '{ 300, 1, 1, 1, 0, 0, 236};
    tbl[4]  = '{ 575, 1, 1, 1, 0, 0, 511};
    tbl[5]  = '{ 576, 1, 0, 1, 0, 0,   0};
    tbl[6]  = '{ 639, 1, 0, 1, 0, 0,   0};
    tbl[7]  = '{ 640, 0, 0, 1, 0, 0,   0};
    tbl[8]  = '{ 655, 0, 0, 1, 0, 0,   0};
    tbl[9]  = '{ 656, 0, 0, 0, 0, 0,   0};
    tbl[10] = '{ 751, 0, 0, 0, 0, 0,   0};
    tbl[11] = '{ 799, 0, 0, 1, 0, 0,   0};

    // Reset with pixEn high, then release with pixEn low.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_reset_state("rst");

    // Line 0 of the default timing, table checkpoints.
    cur = -1; hs_low = 0; ha_high = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].h) begin
        step(1'b1, 1'b1);
        cur++;
        if (!d_hs) hs_low++;
        if (d_ha) ha_high++;
      end
      chk($sformatf("tbl%0d_hCount", i), int'(d_h), tbl[i].h);
      chk($sformatf("tbl%0d_vCount", i), int'(d_v), 0);
      chk($sformatf("tbl%0d_hActive", i), int'(d_ha), int'(tbl[i].ha));
      chk($sformatf("tbl%0d_vActive", i), int'(d_va), 1);
      chk($sformatf("tbl%0d_hSEActive", i), int'(d_hse), int'(tbl[i].hse));
      chk($sformatf("tbl%0d_vSEActive", i), int'(d_vse), 0);
      chk($sformatf("tbl%0d_hSync", i), int'(d_hs), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_pol_hSync", i), int'(p_hs), int'(!tbl[i].hs));
      chk($sformatf("tbl%0d_lineStart", i), int'(d_ls), int'(tbl[i].ls));
      chk($sformatf("tbl%0d_frameStart", i), int'(d_fs), int'(tbl[i].fs));
      chk($sformatf("tbl%0d_seX", i), int'(d_sx), SE_EN ? tbl[i].sx : 0);
      chk($sformatf("tbl%0d_pol_seX", i), int'(p_sx), SE_EN ? tbl[i].sx : 0);
    end
    chk("line0_hsync_low_cycles", hs_low, 96);
    chk("line0_hactive_cycles", ha_high, 640);

    // Line 1 with pixEn alternating 1/0.
    mh = 0; mv = 1; cnt_err = 0; stb_err = 0; dbl = 0; ls_cnt = 0; hs_low = 0;
    prev_ls = 1'b0; prev_fs = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      en = (i % 2 == 0);
      step(en, 1'b1);
      if (i == 0) begin
        chk("line1_vCount", int'(d_v), 1);
        chk("line1_lineStart", int'(d_ls), 1);
        chk("line1_frameStart", int'(d_fs), 0);
      end
      if (int'(d_h) != mh || int'(d_v) != mv) cnt_err++;
      if (d_ls !== (en && mh == 0)) stb_err++;
      if (d_fs !== (en && mh == 0 && mv == 0)) stb_err++;
      if ((d_ls && prev_ls) || (d_fs && prev_fs)) dbl++;
      if (d_ls) ls_cnt++;
      if (!d_hs) hs_low++;
      prev_ls = d_ls; prev_fs = d_fs;
      if (en) begin
        if (mh == 799) begin
          mh = 0;
          mv = (mv == 524) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
    chk("toggle_count_errors", cnt_err, 0);
    chk("toggle_strobe_errors", stb_err, 0);
    chk("toggle_double_strobes", dbl, 0);
    chk("toggle_linestarts", ls_cnt, 1);
    chk("toggle_hsync_low_clocks", hs_low, 192);
    chk("toggle_end_vCount", int'(d_v), 2);

    // Mid-frame reset at hCount=300.
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("prerst_hCount", int'(d_h), 300);
    chk("prerst_vCount", int'(d_v), 2);
    step(1'b0, 1'b1);
    check_reset_state("midrst");
    step(1'b1, 1'b1);
    chk("postrst_hCount", int'(d_h), 0);
    chk("postrst_vCount", int'(d_v), 0);
    chk("postrst_lineStart", int'(d_ls), 1);
    chk("postrst_frameStart", int'(d_fs), 1);
    step(1'b1, 1'b1);
    chk("postrst2_hCount", int'(d_h), 1);
    chk("postrst2_lineStart", int'(d_ls), 0);
    chk("postrst2_frameStart", int'(d_fs), 0);

    // Small configuration: two full frames plus one pixel.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("small_rst_hCount", int'(s_h), 0);
    chk("small_rst_vCount", int'(s_v), 0);
    chk("small_rst_hSync", int'(s_hs), 1);
    chk("small_rst_hSEActive", int'(s_hse), 0);
    mh = 0; mv = 0; cnt_err = 0; f_err = 0; stb_err = 0; a_err = 0;
    fs_cnt = 0; hs_low = 0;
    for (int k = 0; k < 481; k++) begin
      bit e_ha, e_va, e_hse, e_vse, e_hs, e_vs;
      step(1'b1, 1'b1);
      e_ha  = (mh < 16);
      e_va  = (mv < 10);
      e_hse = (mh >= 2 && mh < 10);
      e_vse = (mv >= 3 && mv < 8);
      e_hs  = !(mh >= 17 && mh < 19);
      e_vs  = !(mv >= 10 && mv < 12);
      if (int'(s_h) != mh || int'(s_v) != mv) cnt_err++;
      if (s_ha !== e_ha || s_va !== e_va || s_hse !== e_hse || s_vse !== e_vse ||
          s_hs !== e_hs || s_vs !== e_vs) f_err++;
      if (s_ls !== (mh == 0) || s_fs !== (mh == 0 && mv == 0)) stb_err++;
      if (int'(s_sx) != ((SE_EN && e_hse) ? mh - 2 : 0)) a_err++;
      if (!SE_EN || (e_hse && e_vse)) begin
        if (int'(s_sy) != (SE_EN ? mv - 3 : 0)) a_err++;
      end
      if (s_fs) begin
        if (fs_cnt < 3) fs_at[fs_cnt] = k;
        fs_cnt++;
      end
      if (k < 240 && !s_vs) hs_low++;
      if (k == 20) begin
        chk("small_hwrap_hCount", int'(s_h), 0);
        chk("small_hwrap_vCount", int'(s_v), 1);
      end
      if (k == 239) begin
        chk("small_last_hCount", int'(s_h), 19);
        chk("small_last_vCount", int'(s_v), 11);
      end
      if (k == 240) begin
        chk("small_vwrap_hCount", int'(s_h), 0);
        chk("small_vwrap_vCount", int'(s_v), 0);
        chk("small_vwrap_frameStart", int'(s_fs), 1);
      end
      if (k == 62) chk("small_seX_first", int'(s_sx), 0);           // v3 h2
      if (k == 69) chk("small_seX_last", int'(s_sx), SE_EN ? 7 : 0); // v3 h9
      if (k == 142) chk("small_seY_last", int'(s_sy), SE_EN ? 4 : 0); // v7 h2
      if (k == 162) chk("small_seY_after", int'(s_sy), 0);           // v8 h2
      if (mh == 19) begin
        mh = 0;
        mv = (mv == 11) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    chk("small_count_errors", cnt_err, 0);
    chk("small_flag_errors", f_err, 0);
    chk("small_strobe_errors", stb_err, 0);
    chk("small_addr_errors", a_err, 0);
    chk("small_vsync_low_clocks", hs_low, 40);
    chk("small_framestarts", fs_cnt, 3);
    if (fs_cnt == 3) begin
      chk("small_frame_len1", fs_at[1] - fs_at[0], 240);
      chk("small_frame_len2", fs_at[2] - fs_at[1], 240);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
